// File: rtl/mips_pkg.sv
// mips_pkg: shared types and constants for the writeback/regfile/syscall slice
package mips_pkg;
  localparam int DATA_W = 32;
  localparam logic [4:0] ZERO_IDX = 5'd0;
  localparam logic [4:0] V0_IDX = 5'd2;
  localparam logic [4:0] A0_IDX = 5'd4;
  localparam logic [DATA_W-1:0] SYS_PRINT_INT = 32'd1;
  localparam logic [DATA_W-1:0] SYS_PRINT_CHAR = 32'd11;
  localparam logic [DATA_W-1:0] SYS_EXIT = 32'd10;
  localparam logic CON_INT = 1'b0;
  localparam logic CON_CHAR = 1'b1;
  typedef enum logic [1:0] {IDLE, SEND, DONE, HALT} state_t;
endpackage

// File: rtl/mips_regfile.sv
// mips_regfile: 32x32 register file, $0 hardwired to zero, write-through bypass on every read port
module mips_regfile
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_we,
  input  logic [4:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [4:0]        i_a1,
  input  logic [4:0]        i_a2,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_v0,
  output logic [DATA_W-1:0] o_a0
);
  logic [DATA_W-1:0] r_regs [32];
  logic              w_we;
  assign w_we = i_we && i_wa != ZERO_IDX;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[i_wa] <= i_wd;
    end
  end
  assign o_rd1 = i_a1 == ZERO_IDX ? '0 : (w_we && i_a1 == i_wa) ? i_wd : r_regs[i_a1];
  assign o_rd2 = i_a2 == ZERO_IDX ? '0 : (w_we && i_a2 == i_wa) ? i_wd : r_regs[i_a2];
  assign o_v0  = (w_we && i_wa == V0_IDX) ? i_wd : r_regs[V0_IDX];
  assign o_a0  = (w_we && i_wa == A0_IDX) ? i_wd : r_regs[A0_IDX];
endmodule

// File: rtl/wb_regfile_syscall.sv
// wb_regfile_syscall: writeback mux, register file and syscall console/halt FSM
module wb_regfile_syscall
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWriteW,
  input  logic              MemtoRegW,
  input  logic              SyscallW,
  input  logic [DATA_W-1:0] ReadDataW,
  input  logic [DATA_W-1:0] ALUOutW,
  input  logic [4:0]        WriteRegW,
  input  logic [4:0]        A1,
  input  logic [4:0]        A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] ResultW,
  output logic              StallW,
  output logic              con_valid,
  output logic              con_type,
  output logic [DATA_W-1:0] con_data,
  input  logic              con_ready,
  output logic              halted
);
  state_t            r_state, w_next;
  logic              r_con_valid, r_con_type;
  logic [DATA_W-1:0] r_con_data;
  logic [DATA_W-1:0] w_v0, w_a0;
  logic              w_we, w_send, w_is_char, w_is_print, w_is_exit;
  assign ResultW = MemtoRegW ? ReadDataW : ALUOutW;
  assign w_we = RegWriteW && r_state != HALT;
  mips_regfile u_rf (
    .clk   (clk),
    .reset (reset),
    .i_we  (w_we),
    .i_wa  (WriteRegW),
    .i_wd  (ResultW),
    .i_a1  (A1),
    .i_a2  (A2),
    .o_rd1 (RD1),
    .o_rd2 (RD2),
    .o_v0  (w_v0),
    .o_a0  (w_a0)
  );
  assign w_is_char  = w_v0 == SYS_PRINT_CHAR;
  assign w_is_print = w_is_char || w_v0 == SYS_PRINT_INT;
  assign w_is_exit  = w_v0 == SYS_EXIT;
  always_comb begin
    w_next = r_state;
    StallW = 1'b0;
    w_send = 1'b0;
    case (r_state)
      IDLE: begin
        w_send = SyscallW && w_is_print;
        StallW = SyscallW && (w_is_print || w_is_exit);
        w_next = w_send ? SEND : (SyscallW && w_is_exit) ? HALT : IDLE;
      end
      SEND: begin
        StallW = 1'b1;
        w_next = con_ready ? DONE : SEND;
      end
      DONE: w_next = IDLE;
      HALT: StallW = 1'b1;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_con_valid <= 1'b0;
      r_con_type  <= CON_INT;
      r_con_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_send) begin
        r_con_valid <= 1'b1;
        r_con_type  <= w_is_char ? CON_CHAR : CON_INT;
        r_con_data  <= w_is_char ? {24'b0, w_a0[7:0]} : w_a0;
      end else if (r_state == SEND && con_ready) begin
        r_con_valid <= 1'b0;
      end
    end
  end
  assign con_valid = r_con_valid;
  assign con_type  = r_con_type;
  assign con_data  = r_con_data;
  assign halted    = r_state == HALT;
endmodule

// File: tb/tb_wb_regfile_syscall.sv
// tb_wb_regfile_syscall: table-driven regfile vectors plus directed syscall sequences
module tb_wb_regfile_syscall;
  logic        clk = 1'b0;
  logic        reset, RegWriteW, MemtoRegW, SyscallW, con_ready;
  logic [31:0] ReadDataW, ALUOutW;
  logic [4:0]  WriteRegW, A1, A2;
  logic [31:0] RD1, RD2, ResultW, con_data;
  logic        StallW, con_valid, con_type, halted;
  int          checks = 0;
  int          failures = 0;

  typedef struct {
    logic        we, m2r;
    logic [31:0] rdata, alu;
    logic [4:0]  wreg, a1, a2;
    logic [31:0] e1, e2, er;
  } vec_t;
  vec_t vt [10];

  always #5 clk = ~clk;

  wb_regfile_syscall dut (
    .clk       (clk),
    .reset     (reset),
    .RegWriteW (RegWriteW),
    .MemtoRegW (MemtoRegW),
    .SyscallW  (SyscallW),
    .ReadDataW (ReadDataW),
    .ALUOutW   (ALUOutW),
    .WriteRegW (WriteRegW),
    .A1        (A1),
    .A2        (A2),
    .RD1       (RD1),
    .RD2       (RD2),
    .ResultW   (ResultW),
    .StallW    (StallW),
    .con_valid (con_valid),
    .con_type  (con_type),
    .con_data  (con_data),
    .con_ready (con_ready),
    .halted    (halted)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", n, act, exp);
    end
  endtask

  task automatic set_reg(input logic [4:0] r, input logic [31:0] v);
    @(negedge clk);
    RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUOutW = v; WriteRegW = r; SyscallW = 1'b0;
    @(posedge clk);
    #1 RegWriteW = 1'b0;
  endtask

  initial begin
    vt[0] = '{1'b0, 1'b0, 32'h0,        32'h0,    5'd0,  5'd8,  5'd0,  32'h0,        32'h0,        32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h0,        32'h1234, 5'd8,  5'd8,  5'd3,  32'h1234,     32'h0,        32'h1234};
    vt[2] = '{1'b0, 1'b0, 32'h0,        32'h0,    5'd8,  5'd8,  5'd3,  32'h1234,     32'h0,        32'h0};
    vt[3] = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h5,    5'd0,  5'd0,  5'd8,  32'h0,        32'h1234,     32'hFFFFFFFF};
    vt[4] = '{1'b0, 1'b0, 32'h0,        32'h0,    5'd0,  5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    vt[5] = '{1'b1, 1'b1, 32'hA5A50001, 32'h7,    5'd31, 5'd31, 5'd31, 32'hA5A50001, 32'hA5A50001, 32'hA5A50001};
    vt[6] = '{1'b0, 1'b0, 32'h0,        32'h0,    5'd31, 5'd31, 5'd8,  32'hA5A50001, 32'h1234,     32'h0};
    vt[7] = '{1'b1, 1'b0, 32'h0,        32'h55,   5'd8,  5'd8,  5'd31, 32'h55,       32'hA5A50001, 32'h55};
    vt[8] = '{1'b0, 1'b0, 32'h0,        32'h0,    5'd8,  5'd8,  5'd0,  32'h55,       32'h0,        32'h0};
    vt[9] = '{1'b0, 1'b0, 32'h0,        32'h99,   5'd8,  5'd8,  5'd0,  32'h55,       32'h0,        32'h99};

    reset = 1'b1; RegWriteW = 0; MemtoRegW = 0; SyscallW = 0; con_ready = 0;
    ReadDataW = 0; ALUOutW = 0; WriteRegW = 0; A1 = 0; A2 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rst_valid", {31'b0, con_valid}, 32'h0);
    chk("rst_type", {31'b0, con_type}, 32'h0);
    chk("rst_data", con_data, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_stall", {31'b0, StallW}, 32'h0);

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RegWriteW = vt[i].we; MemtoRegW = vt[i].m2r; ReadDataW = vt[i].rdata; ALUOutW = vt[i].alu;
      WriteRegW = vt[i].wreg; A1 = vt[i].a1; A2 = vt[i].a2;
      #1;
      chk($sformatf("v%0d_rd1", i), RD1, vt[i].e1);
      chk($sformatf("v%0d_rd2", i), RD2, vt[i].e2);
      chk($sformatf("v%0d_res", i), ResultW, vt[i].er);
      chk($sformatf("v%0d_stall", i), {31'b0, StallW}, 32'h0);
    end
    @(posedge clk); #1 RegWriteW = 1'b0; MemtoRegW = 1'b0;

    // print int, console holds ready low for three SEND cycles
    set_reg(5'd2, 32'd1);
    set_reg(5'd4, 32'hDEADBEEF);
    @(negedge clk); SyscallW = 1'b1; con_ready = 1'b0;
    #1;
    chk("pi_idle_stall", {31'b0, StallW}, 32'h1);
    chk("pi_idle_valid", {31'b0, con_valid}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk($sformatf("pi_send%0d_stall", k), {31'b0, StallW}, 32'h1);
      chk($sformatf("pi_send%0d_valid", k), {31'b0, con_valid}, 32'h1);
      chk($sformatf("pi_send%0d_data", k), con_data, 32'hDEADBEEF);
      chk($sformatf("pi_send%0d_type", k), {31'b0, con_type}, 32'h0);
    end
    @(negedge clk); con_ready = 1'b1;
    #1;
    chk("pi_acc_stall", {31'b0, StallW}, 32'h1);
    chk("pi_acc_valid", {31'b0, con_valid}, 32'h1);
    @(negedge clk); con_ready = 1'b0;
    #1;
    chk("pi_done_stall", {31'b0, StallW}, 32'h0);
    chk("pi_done_valid", {31'b0, con_valid}, 32'h0);
    @(negedge clk); SyscallW = 1'b0;
    #1;
    chk("pi_idle2_stall", {31'b0, StallW}, 32'h0);
    chk("pi_idle2_valid", {31'b0, con_valid}, 32'h0);

    // print char; $v0 written in the syscall cycle itself must be seen via bypass
    set_reg(5'd4, 32'h00000141);
    @(negedge clk);
    RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUOutW = 32'd11; WriteRegW = 5'd2; SyscallW = 1'b1; con_ready = 1'b1;
    #1;
    chk("pc_idle_stall", {31'b0, StallW}, 32'h1);
    @(negedge clk); RegWriteW = 1'b0;
    #1;
    chk("pc_send_stall", {31'b0, StallW}, 32'h1);
    chk("pc_send_valid", {31'b0, con_valid}, 32'h1);
    chk("pc_send_data", con_data, 32'h00000041);
    chk("pc_send_type", {31'b0, con_type}, 32'h1);
    @(negedge clk); #1;
    chk("pc_done_stall", {31'b0, StallW}, 32'h0);
    chk("pc_done_valid", {31'b0, con_valid}, 32'h0);
    @(negedge clk); SyscallW = 1'b0; con_ready = 1'b0;

    // unknown code is a no-op
    set_reg(5'd2, 32'd7);
    @(negedge clk); SyscallW = 1'b1;
    #1;
    chk("nop_stall", {31'b0, StallW}, 32'h0);
    @(negedge clk); SyscallW = 1'b0;
    #1;
    chk("nop_stall2", {31'b0, StallW}, 32'h0);
    chk("nop_valid", {31'b0, con_valid}, 32'h0);

    // exit halts; writes blocked until reset
    set_reg(5'd5, 32'h77);
    set_reg(5'd2, 32'd10);
    @(negedge clk); SyscallW = 1'b1;
    #1;
    chk("ex_idle_stall", {31'b0, StallW}, 32'h1);
    chk("ex_idle_halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    SyscallW = 1'b0; RegWriteW = 1'b1; MemtoRegW = 1'b0; ALUOutW = 32'h1111; WriteRegW = 5'd5; A1 = 5'd5;
    #1;
    chk("ex_halted", {31'b0, halted}, 32'h1);
    chk("ex_stall", {31'b0, StallW}, 32'h1);
    chk("ex_nobypass", RD1, 32'h77);
    @(negedge clk); RegWriteW = 1'b0;
    #1;
    chk("ex_reg5", RD1, 32'h77);
    chk("ex_halted2", {31'b0, halted}, 32'h1);
    chk("ex_valid", {31'b0, con_valid}, 32'h0);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; A2 = 5'd8;
    #1;
    chk("ex_rst_halted", {31'b0, halted}, 32'h0);
    chk("ex_rst_stall", {31'b0, StallW}, 32'h0);
    chk("ex_rst_reg5", RD1, 32'h0);
    chk("ex_rst_reg8", RD2, 32'h0);

    // reset while a print request is outstanding
    set_reg(5'd2, 32'd1);
    set_reg(5'd4, 32'h3);
    @(negedge clk); SyscallW = 1'b1; con_ready = 1'b0;
    @(negedge clk); #1;
    chk("rs_valid_pre", {31'b0, con_valid}, 32'h1);
    SyscallW = 1'b0; reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    #1;
    chk("rs_valid", {31'b0, con_valid}, 32'h0);
    chk("rs_stall", {31'b0, StallW}, 32'h0);
    chk("rs_data", con_data, 32'h0);
    @(negedge clk); #1;
    chk("rs_idle_stall", {31'b0, StallW}, 32'h0);
    chk("rs_idle_valid", {31'b0, con_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
